// File: rtl/game_pkg.sv
// Shared game constants: FSM state encoding, score/level widths and limits
// used by the score controller and the game-logic blocks.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } game_state_e;

    localparam int unsigned SCORE_W       = 10;
    localparam int unsigned LEVEL_W       = 3;
    localparam int unsigned HUND_W        = 7;
    localparam int unsigned MAX_SCORE_DEF = 999;
    localparam logic [LEVEL_W-1:0] LEVEL_CAP = 3'd7;
    localparam logic [HUND_W-1:0]  HUND_LAST = 7'd99;

endpackage

// File: rtl/score_ctrl_if.sv
// Button/collision inputs and score display outputs of the score controller.
interface score_ctrl_if;
    import game_pkg::*;

    logic               start;
    logic               pause;
    logic               collide;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] hi_score;
    logic [LEVEL_W-1:0] level;
    logic               running;
    logic               game_over;

    modport master (
        output start, pause, collide,
        input  score, hi_score, level, running, game_over
    );

    modport slave (
        input  start, pause, collide,
        output score, hi_score, level, running, game_over
    );

endinterface

// File: rtl/tick_gen.sv
// Score prescaler: counts 0..TICK_DIV-1 while enabled and flags the wrap cycle.
module tick_gen #(
    parameter int unsigned TICK_DIV = 25
) (
    input  logic clk2,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

    logic [15:0] count_q;
    logic [15:0] count_d;

    // Next prescaler value; clear wins over enable so a restart always begins at zero.
    always_comb begin
        count_d = count_q;
        tick    = 1'b0;
        if (clear) begin
            count_d = 16'd0;
        end else if (enable) begin
            if (count_q == LAST) begin
                count_d = 16'd0;
                tick    = 1'b1;
            end else begin
                count_d = count_q + 16'd1;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/score_ctrl.sv
// Game score controller: start/pause/collide FSM, saturating score with a
// hundreds-based speed level, and best-score tracking.
module score_ctrl
    import game_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 25,
    parameter int unsigned MAX_SCORE = MAX_SCORE_DEF
) (
    input  logic        clk2,
    input  logic        reset,
    score_ctrl_if.slave bus
);

    localparam logic [SCORE_W-1:0] MAX_S = SCORE_W'(MAX_SCORE);

    game_state_e        state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] hi_q, hi_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [HUND_W-1:0]  hund_q, hund_d;
    logic               running_q, running_d;
    logic               game_over_q, game_over_d;
    logic               start_q, start_d;
    logic               pause_q, pause_d;
    logic               armed_q, armed_d;

    logic start_edge_s;
    logic pause_edge_s;
    logic pre_en_s;
    logic pre_clr_s;
    logic tick_s;

    // Edges are only honoured once the edge registers hold a real sample, so a
    // button already held at reset release needs a fresh press.
    assign start_edge_s = armed_q & bus.start & ~start_q;
    assign pause_edge_s = armed_q & bus.pause & ~pause_q;

    assign pre_en_s  = (state_q == RUN) & ~bus.collide;
    assign pre_clr_s = start_edge_s & ((state_q == IDLE) | (state_q == OVER));

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk2   (clk2),
        .reset  (reset),
        .enable (pre_en_s),
        .clear  (pre_clr_s),
        .tick   (tick_s)
    );

    // Next state and counter updates; collide outranks pause and start in RUN.
    always_comb begin
        state_d = state_q;
        score_d = score_q;
        hi_d    = hi_q;
        level_d = level_q;
        hund_d  = hund_q;
        start_d = bus.start;
        pause_d = bus.pause;
        armed_d = 1'b1;
        case (state_q)
            IDLE, OVER: begin
                if (start_edge_s) begin
                    state_d = RUN;
                    score_d = '0;
                    level_d = '0;
                    hund_d  = '0;
                end else begin
                    state_d = state_q;
                end
            end
            RUN: begin
                if (bus.collide) begin
                    state_d = OVER;
                    if (score_q > hi_q) begin
                        hi_d = score_q;
                    end else begin
                        hi_d = hi_q;
                    end
                end else begin
                    if (pause_edge_s) begin
                        state_d = PAUSE;
                    end else begin
                        state_d = RUN;
                    end
                    if (tick_s && (score_q < MAX_S)) begin
                        score_d = score_q + 10'd1;
                        if (hund_q == HUND_LAST) begin
                            hund_d = '0;
                            if (level_q != LEVEL_CAP) begin
                                level_d = level_q + 3'd1;
                            end else begin
                                level_d = level_q;
                            end
                        end else begin
                            hund_d = hund_q + 7'd1;
                        end
                    end else begin
                        score_d = score_q;
                    end
                end
            end
            PAUSE: begin
                if (pause_edge_s) begin
                    state_d = RUN;
                end else begin
                    state_d = PAUSE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        running_d   = (state_d == RUN);
        game_over_d = (state_d == OVER);
    end

    // State, counters, edge registers and registered status outputs.
    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            score_q     <= '0;
            hi_q        <= '0;
            level_q     <= '0;
            hund_q      <= '0;
            running_q   <= 1'b0;
            game_over_q <= 1'b0;
            start_q     <= 1'b0;
            pause_q     <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            hi_q        <= hi_d;
            level_q     <= level_d;
            hund_q      <= hund_d;
            running_q   <= running_d;
            game_over_q <= game_over_d;
            start_q     <= start_d;
            pause_q     <= pause_d;
            armed_q     <= armed_d;
        end
    end

    assign bus.score     = score_q;
    assign bus.hi_score  = hi_q;
    assign bus.level     = level_q;
    assign bus.running   = running_q;
    assign bus.game_over = game_over_q;

endmodule

// File: doc/score_ctrl.md
SCORE_CTRL -- requirements
Module: score_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25, meaning clk2 cycles per score point while running (legal range 2..65535).
REQ-002 SHALL have parameter MAX_SCORE, default 999, meaning the score saturation value.
REQ-003 SHALL have port clk2 input 1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset input 1, asynchronous active-low reset.
REQ-005 SHALL have port start input 1, level start/restart button, synchronous to clk2.
REQ-006 SHALL have port pause input 1, level pause button, synchronous to clk2.
REQ-007 SHALL have port collide input 1, collision flag from the game logic.
REQ-008 SHALL have port score output 10, current score, 0..MAX_SCORE, drives the score display block.
REQ-009 SHALL have port hi_score output 10, best score since reset.
REQ-010 SHALL have port level output 3, speed level = min(score/100, 7).
REQ-011 SHALL have port running output 1, high only in state RUN.
REQ-012 SHALL have port game_over output 1, high only in state OVER.

Function
REQ-013 SHALL detect rising edges of start and pause using one registered copy of each; held levels SHALL act once.
REQ-014 SHALL implement FSM states IDLE, RUN, PAUSE, OVER.
REQ-015 IDLE: start edge -> RUN with score=0, level=0, prescaler=0.
REQ-016 RUN: collide=1 -> OVER; else pause edge -> PAUSE; collide has priority over pause and start in the same cycle.
REQ-017 PAUSE: pause edge -> RUN; prescaler, score and level SHALL freeze; collide and start ignored.
REQ-018 OVER: start edge -> RUN with score=0, level=0, prescaler=0; hi_score retained.
REQ-019 In RUN, prescaler SHALL count 0..TICK_DIV-1 and wrap; score SHALL increment by 1 in the cycle the prescaler wraps, so first point appears TICK_DIV cycles after entering RUN.
REQ-020 score SHALL saturate at MAX_SCORE; further ticks SHALL not change score or level.
REQ-021 level SHALL be derived by a hundreds sub-counter (0..99) incrementing level on wrap, saturating at 7; no divider.
REQ-022 On the RUN->OVER transition hi_score SHALL load score if score > hi_score, visible the cycle game_over first reads 1.
REQ-023 A tick and a collide in the same cycle: collide wins, score not incremented.
REQ-024 All outputs SHALL be registered; running/game_over SHALL change in the same cycle as the state register.

Reset
REQ-025 reset low SHALL asynchronously force state IDLE, score=0, hi_score=0, level=0, prescaler=0, edge registers=0, running=0, game_over=0.
REQ-026 reset asserted mid-RUN SHALL discard the score and hi_score with no further tick.
REQ-027 Release of reset with start held high SHALL not start a game (edge register resets to 0, but a 0->1 transition is required after release; edge register loads start value on first clock before detection is armed).

Structure
REQ-028 State encoding constants and MAX_SCORE/level cap SHALL live in a shared package game_pkg used by score and game-logic blocks.
REQ-029 Prescaler SHALL be a sub-module tick_gen (enable, clear, tick out); FSM and counters stay in score_ctrl.

Verification
REQ-030 Reset, start pulse, TICK_DIV=25 -> score=1 exactly 25 cycles after running rises, score=4 after 100 cycles.
REQ-031 Run to score=137, collide pulse -> game_over=1, score=137, hi_score=137, level=1; restart, collide at 50 -> hi_score stays 137.
REQ-032 pause edge at score=20, hold 200 cycles, pause edge -> score still 20 during PAUSE, next point 25-prescaler cycles after resume.
REQ-033 Force run past 999 (TICK_DIV=2) -> score stays 999, level=7.
REQ-034 collide, pause edge and tick in one cycle -> OVER, score unchanged; start held high across reset release -> stays IDLE.
REQ-035 reset pulse mid-RUN at score=300 -> all outputs 0 asynchronously, before next clk2 edge.
